// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with cyc-locked round-robin
// grants and an optional watchdog that errors out hung strobes.
module wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [XLEN-1:0]   i_adr,
  input  logic [XLEN-1:0]   i_dat_w,
  input  logic [XLEN/8-1:0] i_sel,
  output logic              i_ack,
  output logic              i_err,
  output logic [XLEN-1:0]   i_dat_r,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_adr,
  input  logic [XLEN-1:0]   d_dat_w,
  input  logic [XLEN/8-1:0] d_sel,
  output logic              d_ack,
  output logic              d_err,
  output logic [XLEN-1:0]   d_dat_r,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [XLEN-1:0]   s_adr,
  output logic [XLEN-1:0]   s_dat_w,
  output logic [XLEN/8-1:0] s_sel,
  input  logic              s_ack,
  input  logic              s_err,
  input  logic [XLEN-1:0]   s_dat_r,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  // 1 = data master held the bus last
  logic   last_d_q, last_d_d;
  logic   own_cyc, own_stb;
  logic   wd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state_q)
      OWN_I: begin
        own_cyc = i_cyc;
        own_stb = i_stb;
      end
      OWN_D: begin
        own_cyc = d_cyc;
        own_stb = d_stb;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (state_q == IDLE || !own_cyc) begin
      if (i_cyc && (!d_cyc || last_d_q)) begin
        state_d  = OWN_I;
        last_d_d = 1'b0;
      end else if (d_cyc) begin
        state_d  = OWN_D;
        last_d_d = 1'b1;
      end else begin
        state_d  = IDLE;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] wd_q, wd_d, wd_inc;
    logic         wait_c;

    // err fires on the TIMEOUT-th consecutive waiting cycle
    always_comb begin
      wait_c = own_stb & ~s_ack & ~s_err;
      wd_inc = wd_q + W'(1);
      wd_err = wait_c && (wd_inc == W'(TIMEOUT));
      wd_d   = '0;
      if (wait_c && !wd_err && state_d == state_q)
        wd_d = wd_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
    end
  end else begin : g_no_wd
    assign wd_err = 1'b0;
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    i_ack   = 1'b0;
    i_err   = 1'b0;
    d_ack   = 1'b0;
    d_err   = 1'b0;
    case (state_q)
      OWN_I: begin
        s_cyc   = i_cyc;
        s_stb   = i_stb;
        s_we    = i_we;
        s_adr   = i_adr;
        s_dat_w = i_dat_w;
        s_sel   = i_sel;
        i_ack   = s_ack;
        i_err   = s_err | wd_err;
      end
      OWN_D: begin
        s_cyc   = d_cyc;
        s_stb   = d_stb;
        s_we    = d_we;
        s_adr   = d_adr;
        s_dat_w = d_dat_w;
        s_sel   = d_sel;
        d_ack   = s_ack;
        d_err   = s_err | wd_err;
      end
      default: ;
    endcase
  end

  assign gnt     = {state_q == OWN_D, state_q == OWN_I};
  assign i_dat_r = s_dat_r;
  assign d_dat_r = s_dat_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: grant order, cyc lock,
// pass-through, watchdog and async reset.
module tb_wb_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_cyc, i_stb, i_we;
  logic [XLEN-1:0] i_adr, i_dat_w;
  logic [3:0]      i_sel;
  logic            i_ack, i_err;
  logic [XLEN-1:0] i_dat_r;
  logic            d_cyc, d_stb, d_we;
  logic [XLEN-1:0] d_adr, d_dat_w;
  logic [3:0]      d_sel;
  logic            d_ack, d_err;
  logic [XLEN-1:0] d_dat_r;
  logic            s_cyc, s_stb, s_we;
  logic [XLEN-1:0] s_adr, s_dat_w;
  logic [3:0]      s_sel;
  logic            s_ack, s_err;
  logic [XLEN-1:0] s_dat_r;
  logic [1:0]      gnt;

  int nvec = 0;
  int nerr = 0;

  wb_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel),
    .i_ack(i_ack), .i_err(i_err), .i_dat_r(i_dat_r),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we),
    .d_adr(d_adr), .d_dat_w(d_dat_w), .d_sel(d_sel),
    .d_ack(d_ack), .d_err(d_err), .d_dat_r(d_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    i_cyc = 0; i_stb = 0; i_we = 0;
    i_adr = '0; i_dat_w = '0; i_sel = '0;
    d_cyc = 0; d_stb = 0; d_we = 0;
    d_adr = '0; d_dat_w = '0; d_sel = '0;
    s_ack = 0; s_err = 0; s_dat_r = '0;
  endtask

  task automatic do_reset;
    quiet();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    quiet();
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_scyc", 64'(s_cyc), 64'd0);
    chk("rst_acks", 64'({i_ack, i_err, d_ack, d_err}), 64'd0);
    tick();
    rst = 0;

    // I alone, slave acks on the 2nd owned cycle
    i_cyc = 1; i_stb = 1; i_adr = 32'h100;
    #1;
    chk("t1_nocomb_gnt", 64'(gnt), 64'd0);
    chk("t1_nocomb_scyc", 64'(s_cyc), 64'd0);
    tick();
    chk("t1_gnt", 64'(gnt), 64'd1);
    chk("t1_sadr", 64'(s_adr), 64'h100);
    chk("t1_noack", 64'(i_ack), 64'd0);
    tick();
    s_ack = 1; s_dat_r = 32'hDEADBEEF;
    #1;
    chk("t1_iack", 64'(i_ack), 64'd1);
    chk("t1_idat", 64'(i_dat_r), 64'hDEADBEEF);
    chk("t1_dack", 64'(d_ack), 64'd0);
    chk("t1_ierr", 64'(i_err), 64'd0);
    tick();
    s_ack = 0; i_cyc = 0; i_stb = 0;
    #1;
    chk("t1_drop_scyc", 64'(s_cyc), 64'd0);
    chk("t1_drop_iack", 64'(i_ack), 64'd0);
    tick();
    chk("t1_idle", 64'(gnt), 64'd0);

    // tie after reset, direct handover, second tie
    do_reset();
    i_cyc = 1; i_stb = 1; i_adr = 32'h20;
    d_cyc = 1; d_stb = 1; d_adr = 32'h40;
    tick();
    chk("t2_tie1", 64'(gnt), 64'd1);
    chk("t2_sadr", 64'(s_adr), 64'h20);
    i_cyc = 0; i_stb = 0;
    #1;
    chk("t2_drop_scyc", 64'(s_cyc), 64'd0);
    tick();
    chk("t2_handover", 64'(gnt), 64'd2);
    chk("t2_scyc_d", 64'(s_cyc), 64'd1);
    chk("t2_sadr_d", 64'(s_adr), 64'h40);
    d_cyc = 0; d_stb = 0;
    tick();
    chk("t2_idle", 64'(gnt), 64'd0);
    i_cyc = 1; d_cyc = 1;
    tick();
    chk("t2_tie2", 64'(gnt), 64'd1);
    quiet();
    tick();
    chk("t2_idle2", 64'(gnt), 64'd0);

    // D wins the tie (last=I) and holds through 3 beats
    i_cyc = 1; i_stb = 1;
    d_cyc = 1;
    tick();
    chk("t3_gnt", 64'(gnt), 64'd2);
    for (int k = 0; k < 3; k++) begin
      d_stb = 1; d_adr = 32'(4 * k); s_ack = 1;
      #1;
      chk("t3_sadr", 64'(s_adr), 64'(4 * k));
      chk("t3_dack", 64'(d_ack), 64'd1);
      chk("t3_iack", 64'(i_ack), 64'd0);
      chk("t3_lock", 64'(gnt), 64'd2);
      tick();
    end
    s_ack = 0; d_stb = 0; d_cyc = 0;
    tick();
    chk("t3_to_i", 64'(gnt), 64'd1);
    quiet();
    tick();

    // D write, I noise ignored
    d_cyc = 1; d_stb = 1; d_we = 1;
    d_sel = 4'b0011; d_dat_w = 32'h1234;
    d_adr = 32'h200; s_ack = 1;
    tick();
    chk("t4_gnt", 64'(gnt), 64'd2);
    for (int k = 0; k < 4; k++) begin
      i_cyc = 1'($urandom_range(0, 1));
      i_stb = 1'($urandom_range(0, 1));
      i_we = 1'($urandom_range(0, 1));
      i_adr = $urandom;
      i_dat_w = $urandom;
      i_sel = 4'($urandom);
      #1;
      chk("t4_swe", 64'(s_we), 64'd1);
      chk("t4_ssel", 64'(s_sel), 64'h3);
      chk("t4_sdat", 64'(s_dat_w), 64'h1234);
      chk("t4_sadr", 64'(s_adr), 64'h200);
      tick();
    end
    quiet();
    tick();
    chk("t4_idle", 64'(gnt), 64'd0);

    // watchdog: err on 4th waiting cycle only
    i_cyc = 1; i_stb = 1; i_adr = 32'h300;
    tick();
    chk("t5_gnt", 64'(gnt), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t5_wd%0d", k), 64'(i_err), 64'(k == 4));
      tick();
    end
    i_stb = 0;
    tick();
    i_stb = 1; s_err = 1;
    #1;
    chk("t5_serr_i", 64'(i_err), 64'd1);
    chk("t5_serr_d", 64'(d_err), 64'd0);
    s_ack = 1;
    #1;
    chk("t5_both", 64'({i_ack, i_err}), 64'h3);
    tick();
    quiet();
    tick();

    // async reset mid-transfer, then tie after reset
    d_cyc = 1; d_stb = 1; s_ack = 1;
    tick();
    chk("t6_own", 64'({gnt, s_cyc, d_ack}), 64'b1011);
    #2;
    rst = 1;
    #1;
    chk("t6_gnt", 64'(gnt), 64'd0);
    chk("t6_scyc", 64'(s_cyc), 64'd0);
    chk("t6_dack", 64'(d_ack), 64'd0);
    i_cyc = 1; i_stb = 1;
    tick();
    rst = 0;
    tick();
    chk("t6_tie", 64'(gnt), 64'd1);
    quiet();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Lets the core's instruction port (I, from ifu) and data port (D, from lsu) share a single memory/peripheral slave.
- Grants whole bus cycles (cyc-locked) using round-robin fairness.
- Includes an optional watchdog that terminates hung transfers with an error.

Parameters:
- XLEN, 32, address and data width.
- TIMEOUT, 255, cycles a granted strobe may wait for slave ack/err before the arbiter returns err; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_cyc  in  1  instruction master cycle request
- i_stb  in  1  instruction master strobe
- i_we  in  1  instruction master write enable
- i_adr  in  XLEN  instruction master address
- i_dat_w  in  XLEN  instruction master write data
- i_sel  in  XLEN/8  instruction master byte selects
- i_ack  out  1  ack to instruction master
- i_err  out  1  err to instruction master
- i_dat_r  out  XLEN  read data to instruction master
- d_cyc, d_stb, d_we, d_adr, d_dat_w, d_sel, d_ack, d_err, d_dat_r: same as i_*, for the data master
- s_cyc  out  1  slave cycle
- s_stb  out  1  slave strobe
- s_we  out  1  slave write enable
- s_adr  out  XLEN  slave address
- s_dat_w  out  XLEN  slave write data
- s_sel  out  XLEN/8  slave byte selects
- s_ack  in  1  slave ack
- s_err  in  1  slave err
- s_dat_r  in  XLEN  slave read data
- gnt  out  2  current owner, one-hot: bit0 = I, bit1 = D; 00 = idle

Behaviour:
- States:
  - IDLE: no owner.
  - OWN_I: I owns the bus.
  - OWN_D: D owns the bus.
  - State is registered. last_owner flag is registered.
- Reset (async, immediate):
  - state = IDLE, last_owner = D, watchdog = 0.
  - gnt = 00.
  - All s_* outputs 0; i_ack, i_err, d_ack, d_err = 0.
- Decision point: on a rising edge, arbitration occurs when state = IDLE, or when the current owner's cyc is 0.
  - Only one of i_cyc/d_cyc high: grant to it.
  - Both high: grant to the master that is not last_owner.
  - Neither high: go to IDLE.
  - last_owner updates on every grant.
  - Direct handover OWN_I->OWN_D (and reverse) happens in one edge, with no idle cycle.
- Latency: a request raised in cycle N, with the bus free, drives s_cyc in cycle N+1. Arbitration is never combinational on the current cycle's cyc.
- While owning, the owner's cyc/stb/we/adr/dat_w/sel pass combinationally to s_*.
  - Owner receives s_ack and s_dat_r combinationally.
  - Owner receives s_err OR watchdog error.
  - Non-owner receives ack = err = 0. dat_r is s_dat_r to both masters; it is only valid when paired with ack.
- In IDLE, all s_* outputs are 0.
- Lock: ownership holds while the owner's cyc = 1, through any number of stb/ack beats, even if the other master is requesting.
- Owner drops cyc in cycle N:
  - s_cyc = 0 combinationally in N.
  - New decision at the end of N.
- Watchdog (TIMEOUT > 0):
  - Counter width is clog2(TIMEOUT+1).
  - Increments each cycle the owner's stb = 1 and s_ack = s_err = 0.
  - Clears on ack, on err, on stb = 0, and on ownership change.
  - When the counter equals TIMEOUT, the owner's err = 1 for that cycle and the counter clears.
  - The slave is not signalled; the master must end or retry the cycle.
- TIMEOUT = 0: counter absent, err = s_err only.
- Simultaneous s_ack and s_err: pass both to the owner unchanged; the watchdog clears.
- Reset mid-transfer: outputs drop immediately. Any in-flight slave transaction is abandoned; the slave must tolerate cyc falling.

Test Plan:
- Reset, then I alone raises cyc/stb with adr = 0x100, slave acks after 2 cycles with dat_r = 0xDEADBEEF -> gnt = 01 one cycle after request; i_ack pulse with i_dat_r = 0xDEADBEEF; d_ack stays 0.
- I and D raise cyc in the same cycle after reset -> I granted first (last_owner = D). I drops cyc -> gnt = 10 on the next edge with no idle cycle. Next tie -> I granted again.
- D owns and holds cyc across 3 ack'd beats (adr 0x0, 0x4, 0x8) while I requests -> gnt stays 10 for all beats; I granted only after d_cyc falls.
- D write: we = 1, sel = 0b0011, dat_w = 0x1234 -> s_we, s_sel and s_dat_w match exactly while gnt = 10; i_* inputs toggling randomly have no effect on s_*.
- TIMEOUT = 4, owner stb held with the slave silent -> owner err = 1 exactly on the 4th waiting cycle, for 1 cycle. s_err pulse during another transfer -> passed through same cycle.
- Assert rst while OWN_D mid-transfer -> s_cyc, gnt and d_ack go to 0 asynchronously. After release with both requesting -> I granted first.
